// File: rtl/cpu65_pkg.sv
// Shared types and constants for the 65C02 interrupt/halt sequencer.
// Vector encodings match the vec_sel output seen by the microcode controller.
package cpu65_pkg;

    typedef enum logic [2:0] {
        RST  = 3'd0,
        RUN  = 3'd1,
        SVC  = 3'd2,
        WAIT = 3'd3,
        STOP = 3'd4
    } irq_state_t;

    localparam logic [1:0] VEC_RST = 2'b00;   // FFFC
    localparam logic [1:0] VEC_NMI = 2'b01;   // FFFA
    localparam logic [1:0] VEC_IRQ = 2'b10;   // FFFE, also used by BRK

    localparam logic [8:0] IRQ_UCODE_ENTRY = 9'h168;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchroniser for an asynchronous active-low pin.
// Resets to 1 so the synchronised signal reads as inactive.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ff <= '1;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/irq_ctl.sv
// Interrupt/halt sequencer: synchronises IRQ/NMI, latches NMI edges, and drives
// take_int, the frozen vector select, the B flag and the rdy stall for WAI/STP.
module irq_ctl
    import cpu65_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       irq_n,
    input  logic       nmi_n,
    input  logic       sync,
    input  logic       I,
    input  logic       int_ack,
    input  logic       wai,
    input  logic       stp,
    output logic       take_int,
    output logic [1:0] vec_sel,
    output logic       b_flag,
    output logic       rdy
);

    irq_state_t state, state_nx;

    logic       irq_s, nmi_s, nmi_s_d;
    logic       nmi_edge, nmi_pend, nmi_clr, irq_req;
    logic       take_int_nx, b_flag_nx, rdy_nx;
    logic [1:0] vec_sel_nx;

    // sync is consumed by ctl itself; requests are raised here regardless of boundary.
    logic unused_ok;
    assign unused_ok = sync;

    sync_chain #(.STAGES(SYNC_STAGES)) u_irq_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (irq_n),
        .q       (irq_s)
    );

    sync_chain #(.STAGES(SYNC_STAGES)) u_nmi_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (nmi_n),
        .q       (nmi_s)
    );

    assign nmi_edge = nmi_s_d & ~nmi_s;
    assign irq_req  = ~irq_s & ~I;

    always_comb begin
        state_nx    = state;
        take_int_nx = take_int;
        vec_sel_nx  = vec_sel;
        b_flag_nx   = b_flag;
        rdy_nx      = rdy;
        nmi_clr     = 1'b0;
        case (state)
            RST: begin
                take_int_nx = 1'b1;
                vec_sel_nx  = VEC_RST;
                b_flag_nx   = 1'b0;
                rdy_nx      = 1'b1;
                if (int_ack) begin
                    state_nx    = RUN;
                    take_int_nx = 1'b0;
                    vec_sel_nx  = VEC_IRQ;
                    b_flag_nx   = 1'b1;
                end
            end
            RUN: begin
                take_int_nx = 1'b0;
                b_flag_nx   = 1'b1;
                rdy_nx      = 1'b1;
                // A pending request outranks a WAI/STP issued in the same cycle.
                if (nmi_pend || irq_req) begin
                    state_nx    = SVC;
                    take_int_nx = 1'b1;
                    b_flag_nx   = 1'b0;
                end else if (wai) begin
                    state_nx = WAIT;
                    rdy_nx   = 1'b0;
                end else if (stp) begin
                    state_nx = STOP;
                    rdy_nx   = 1'b0;
                end
            end
            SVC: begin
                take_int_nx = 1'b1;
                b_flag_nx   = 1'b0;
                if (int_ack) begin
                    state_nx    = RUN;
                    take_int_nx = 1'b0;
                    b_flag_nx   = 1'b1;
                    vec_sel_nx  = nmi_pend ? VEC_NMI : VEC_IRQ;
                    nmi_clr     = nmi_pend;
                end
            end
            WAIT: begin
                rdy_nx = 1'b0;
                // Wake on a raw IRQ level even when masked; RUN then decides.
                if (nmi_pend || !irq_s) begin
                    state_nx = RUN;
                    rdy_nx   = 1'b1;
                end
            end
            STOP: begin
                rdy_nx = 1'b0;
            end
            default: begin
                state_nx = RST;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= RST;
            take_int <= 1'b1;
            vec_sel  <= VEC_RST;
            b_flag   <= 1'b0;
            rdy      <= 1'b1;
            nmi_s_d  <= 1'b1;
            nmi_pend <= 1'b0;
        end else begin
            state    <= state_nx;
            take_int <= take_int_nx;
            vec_sel  <= vec_sel_nx;
            b_flag   <= b_flag_nx;
            rdy      <= rdy_nx;
            nmi_s_d  <= nmi_s;
            // A fresh edge in the clearing cycle keeps the NMI pending.
            if (nmi_edge) begin
                nmi_pend <= 1'b1;
            end else if (nmi_clr) begin
                nmi_pend <= 1'b0;
            end
        end
    end

    // int_ack is only meaningful while the reset or interrupt sequence is running.
    ack_in_service: assert property (@(posedge clk) disable iff (!reset_n)
        int_ack |-> (state == RST || state == SVC));

endmodule

// File: tb/tb_irq_ctl.sv
// Cycle-table bench for irq_ctl: each record holds one cycle of inputs and the
// registered outputs expected after that clock edge.
module tb_irq_ctl;

    logic       clk;
    logic       reset_n, irq_n, nmi_n, sync, I, int_ack, wai, stp;
    logic       take_int, b_flag, rdy;
    logic [1:0] vec_sel;

    typedef struct {
        logic       rst_n;
        logic       irq_n;
        logic       nmi_n;
        logic       i;
        logic       ack;
        logic       wai;
        logic       stp;
        logic [4:0] exp;
        string      tag;
    } vec_t;

    vec_t       tbl[$];
    logic [4:0] exp_q[$];
    string      tag_q[$];
    int         n_vec  = 0;
    int         n_fail = 0;

    logic  g_irq_n = 1'b1;
    logic  g_nmi_n = 1'b1;
    logic  g_i     = 1'b0;
    string g_tag   = "reset";

    irq_ctl #(.SYNC_STAGES(2)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .irq_n    (irq_n),
        .nmi_n    (nmi_n),
        .sync     (sync),
        .I        (I),
        .int_ack  (int_ack),
        .wai      (wai),
        .stp      (stp),
        .take_int (take_int),
        .vec_sel  (vec_sel),
        .b_flag   (b_flag),
        .rdy      (rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs packed as {take_int, vec_sel, b_flag, rdy}.
    task automatic add(input logic rst_n, input logic ack, input logic w, input logic s,
                       input logic tk, input logic [1:0] vs, input logic b, input logic r);
        vec_t v;
        v.rst_n = rst_n;
        v.irq_n = g_irq_n;
        v.nmi_n = g_nmi_n;
        v.i     = g_i;
        v.ack   = ack;
        v.wai   = w;
        v.stp   = s;
        v.exp   = {tk, vs, b, r};
        v.tag   = g_tag;
        tbl.push_back(v);
    endtask

    task automatic idle(input int n, input logic tk, input logic [1:0] vs,
                        input logic b, input logic r);
        for (int k = 0; k < n; k++) add(1'b1, 1'b0, 1'b0, 1'b0, tk, vs, b, r);
    endtask

    task automatic build_table();
        // Reset held 3 cycles, then the reset sequence is acknowledged.
        g_tag = "reset";
        for (int k = 0; k < 3; k++) add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1);
        idle(1, 1'b1, 2'b00, 1'b0, 1'b1);
        add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 1'b1);
        idle(1, 1'b0, 2'b10, 1'b1, 1'b1);

        // IRQ: take_int on the third edge after the pin falls; I rising cannot withdraw it.
        g_tag = "irq"; g_irq_n = 1'b0;
        idle(2, 1'b0, 2'b10, 1'b1, 1'b1);
        idle(1, 1'b1, 2'b10, 1'b0, 1'b1);
        g_i = 1'b1;
        idle(2, 1'b1, 2'b10, 1'b0, 1'b1);
        add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 1'b1);
        g_irq_n = 1'b1;
        idle(3, 1'b0, 2'b10, 1'b1, 1'b1);

        // NMI overrides a pending IRQ; a second NMI edge landing on the ack is kept.
        g_tag = "nmi_ovr"; g_i = 1'b0; g_irq_n = 1'b0;
        idle(2, 1'b0, 2'b10, 1'b1, 1'b1);
        idle(1, 1'b1, 2'b10, 1'b0, 1'b1);
        g_i = 1'b1; g_nmi_n = 1'b0;
        idle(1, 1'b1, 2'b10, 1'b0, 1'b1);
        g_nmi_n = 1'b1;
        idle(2, 1'b1, 2'b10, 1'b0, 1'b1);
        g_nmi_n = 1'b0;
        idle(2, 1'b1, 2'b10, 1'b0, 1'b1);
        add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1);
        g_tag = "nmi_again";
        idle(1, 1'b1, 2'b01, 1'b0, 1'b1);
        add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1);
        idle(2, 1'b0, 2'b01, 1'b1, 1'b1);

        // Masked IRQ held low; a 1-cycle NMI pulse still gets through.
        g_tag = "masked"; g_nmi_n = 1'b1;
        idle(50, 1'b0, 2'b01, 1'b1, 1'b1);
        g_tag = "nmi_pulse"; g_nmi_n = 1'b0;
        idle(1, 1'b0, 2'b01, 1'b1, 1'b1);
        g_nmi_n = 1'b1;
        idle(2, 1'b0, 2'b01, 1'b1, 1'b1);
        idle(1, 1'b1, 2'b01, 1'b0, 1'b1);
        add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1);
        g_irq_n = 1'b1;
        idle(3, 1'b0, 2'b01, 1'b1, 1'b1);

        // WAI woken by a masked IRQ: resume without an interrupt.
        g_tag = "wai_masked";
        add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0);
        idle(2, 1'b0, 2'b01, 1'b1, 1'b0);
        g_irq_n = 1'b0;
        idle(2, 1'b0, 2'b01, 1'b1, 1'b0);
        idle(3, 1'b0, 2'b01, 1'b1, 1'b1);
        g_irq_n = 1'b1;
        idle(3, 1'b0, 2'b01, 1'b1, 1'b1);

        // WAI woken by an unmasked IRQ: resume, then service it.
        g_tag = "wai_irq"; g_i = 1'b0;
        add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0);
        g_irq_n = 1'b0;
        idle(2, 1'b0, 2'b01, 1'b1, 1'b0);
        idle(1, 1'b0, 2'b01, 1'b1, 1'b1);
        idle(1, 1'b1, 2'b01, 1'b0, 1'b1);
        g_i = 1'b1;
        add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 1'b1);
        idle(1, 1'b0, 2'b10, 1'b1, 1'b1);
        g_irq_n = 1'b1;
        idle(3, 1'b0, 2'b10, 1'b1, 1'b1);

        // WAI in the same cycle as a qualifying IRQ is dropped.
        g_tag = "wai_vs_svc"; g_i = 1'b0; g_irq_n = 1'b0;
        idle(2, 1'b0, 2'b10, 1'b1, 1'b1);
        add(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 1'b1);
        g_i = 1'b1;
        add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 1'b1);
        g_irq_n = 1'b1;
        idle(3, 1'b0, 2'b10, 1'b1, 1'b1);

        // STP ignores NMI and IRQ; reset discards the NMI latched meanwhile.
        g_tag = "stp"; g_i = 1'b0;
        add(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0);
        g_nmi_n = 1'b0;
        idle(1, 1'b0, 2'b10, 1'b1, 1'b0);
        g_nmi_n = 1'b1; g_irq_n = 1'b0;
        idle(8, 1'b0, 2'b10, 1'b1, 1'b0);
        g_tag = "stp_reset"; g_irq_n = 1'b1;
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1);
        idle(2, 1'b1, 2'b00, 1'b0, 1'b1);
        add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 1'b1);
        idle(3, 1'b0, 2'b10, 1'b1, 1'b1);
    endtask

    task automatic check_cycle();
        logic [4:0] exp;
        logic [4:0] act;
        string      tag;
        exp = exp_q.pop_front();
        tag = tag_q.pop_front();
        act = {take_int, vec_sel, b_flag, rdy};
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s vec %0d: got {take_int,vec_sel,b_flag,rdy}=%b_%b_%b_%b expected %b_%b_%b_%b",
                     tag, n_vec, act[4], act[3:2], act[1], act[0],
                     exp[4], exp[3:2], exp[1], exp[0]);
        end
    endtask

    initial begin
        reset_n = 1'b0; irq_n = 1'b1; nmi_n = 1'b1; sync = 1'b0;
        I = 1'b0; int_ack = 1'b0; wai = 1'b0; stp = 1'b0;
        build_table();
        foreach (tbl[n]) begin
            @(negedge clk);
            reset_n = tbl[n].rst_n;
            irq_n   = tbl[n].irq_n;
            nmi_n   = tbl[n].nmi_n;
            I       = tbl[n].i;
            int_ack = tbl[n].ack;
            wai     = tbl[n].wai;
            stp     = tbl[n].stp;
            sync    = $urandom_range(0, 1) == 1;
            exp_q.push_back(tbl[n].exp);
            tag_q.push_back(tbl[n].tag);
            @(posedge clk);
            #1;
            check_cycle();
        end
        @(negedge clk);
        int_ack = 1'b0; wai = 1'b0; stp = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
